// File: rtl/otter_dmem_lsu.sv
// Load/store unit for OTTER data-memory port 2: one request in flight. Response latency is 1 (error), 2 (store) or 2+READ_LAT (load) cycles.
// REQ_READY is high only in IDLE with RST low; responses are single-cycle pulses with no backpressure. Optional counters via LSU_STATS_EN.
module otter_dmem_lsu #(
    parameter int          READ_LAT  = 1,
    parameter logic [31:0] MMIO_BASE = 32'h0001_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_SIGN,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        RSP_IS_IO,
`ifdef LSU_STATS_EN
    output logic [31:0] STAT_LOADS,
    output logic [31:0] STAT_STORES,
    output logic [31:0] STAT_ERRS,
`endif
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        is_io_q, is_io_d;
    logic        mem_rden_q, mem_rden_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;
    logic [1:0]  mem_size_q, mem_size_d;
    logic        mem_sign_q, mem_sign_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_is_io_q, rsp_is_io_d;

    logic        req_ready;
    logic        accept;
    logic        req_misaligned;
    logic        req_is_io;

    assign req_ready = (state_q == S_IDLE) & ~RST;
    assign accept    = REQ_VALID & req_ready;
    assign req_is_io = (REQ_ADDR >= MMIO_BASE);

    // Halves may straddle into the next byte lane, but never past the word.
    always_comb begin
        req_misaligned = 1'b0;
        case (REQ_SIZE)
            2'd0:    req_misaligned = 1'b0;
            2'd1:    req_misaligned = (REQ_ADDR[1:0] == 2'd3);
            2'd2:    req_misaligned = (REQ_ADDR[1:0] != 2'd0);
            default: req_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        is_io_d     = is_io_q;
        mem_rden_d  = mem_rden_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_size_d  = mem_size_q;
        mem_sign_d  = mem_sign_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        rsp_is_io_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = REQ_WE;
                    is_io_d = req_is_io;
                    if (req_misaligned) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_is_io_d = req_is_io;
                    end else begin
                        state_d    = S_ISSUE;
                        mem_addr_d = REQ_ADDR;
                        mem_size_d = REQ_SIZE;
                        mem_sign_d = REQ_SIGN;
                        if (REQ_WE) begin
                            mem_we_d  = 1'b1;
                            mem_din_d = REQ_WDATA;
                        end else begin
                            mem_rden_d = 1'b1;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    mem_we_d    = 1'b0;
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_is_io_d = is_io_q;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 3'd0;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'(READ_LAT - 1)) begin
                    mem_rden_d  = 1'b0;
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = MEM_DOUT2;
                    rsp_is_io_d = is_io_q;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            we_q        <= 1'b0;
            is_io_q     <= 1'b0;
            mem_rden_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_din_q   <= 32'd0;
            mem_size_q  <= 2'd0;
            mem_sign_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            rsp_is_io_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            is_io_q     <= is_io_d;
            mem_rden_q  <= mem_rden_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_size_q  <= mem_size_d;
            mem_sign_q  <= mem_sign_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_is_io_q <= rsp_is_io_d;
        end
    end

    assign REQ_READY = req_ready;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERR   = rsp_err_q;
    assign RSP_IS_IO = rsp_is_io_q;
    assign MEM_RDEN2 = mem_rden_q;
    assign MEM_WE2   = mem_we_q;
    assign MEM_ADDR2 = mem_addr_q;
    assign MEM_DIN2  = mem_din_q;
    assign MEM_SIZE  = mem_size_q;
    assign MEM_SIGN  = mem_sign_q;

`ifdef LSU_STATS_EN
    logic [31:0] stat_loads_q, stat_loads_d;
    logic [31:0] stat_stores_q, stat_stores_d;
    logic [31:0] stat_errs_q, stat_errs_d;

    // The response type is fully known from the flags held through RESP.
    always_comb begin
        stat_loads_d  = stat_loads_q;
        stat_stores_d = stat_stores_q;
        stat_errs_d   = stat_errs_q;
        if (state_q == S_RESP) begin
            if (rsp_err_q) begin
                stat_errs_d = stat_errs_q + 32'd1;
            end else if (we_q) begin
                stat_stores_d = stat_stores_q + 32'd1;
            end else begin
                stat_loads_d = stat_loads_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_loads_q  <= 32'd0;
            stat_stores_q <= 32'd0;
            stat_errs_q   <= 32'd0;
        end else begin
            stat_loads_q  <= stat_loads_d;
            stat_stores_q <= stat_stores_d;
            stat_errs_q   <= stat_errs_d;
        end
    end

    assign STAT_LOADS  = stat_loads_q;
    assign STAT_STORES = stat_stores_q;
    assign STAT_ERRS   = stat_errs_q;
`endif

endmodule
